pipe_result_collector: RTL and testbench

//  Consumer end of the pipeline2 datapath. Tracks which cycles carried a valid
//  A..D operand set, re-times the valid alongside the fixed pipeline latency,
//  and captures {Y,X} into a small FIFO. Results leave on a valid/ready

---
 rtl/pipe_collect_pkg.sv | 17 +
 rtl/pc_fifo.sv | 49 ++++
 rtl/pipe_result_collector.sv | 74 +++++++
 tb/tb_pipe_result_collector.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/pipe_collect_pkg.sv
// pipe_collect_pkg: shared result type, pipeline latency and helpers for the result collector
package pipe_collect_pkg;

  typedef struct packed {
    logic y;
    logic x;
  } result_t;

  localparam int PIPE2_LAT = 3;

  // Number of set bits, used to count issues still travelling through pipeline2
  function automatic logic [31:0] ones(input logic [31:0] v);
    ones = '0;
    for (int i = 0; i < 32; i++) ones = ones + 32'(v[i]);
  endfunction

endpackage

// File: rtl/pc_fifo.sv
// pc_fifo: synchronous FIFO with registered storage, wrap-around pointers and occupancy count
module pc_fifo
  import pipe_collect_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = result_t
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  T                       din,
  output T                       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  T              mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          wr_en;
  logic          rd_en;

  assign full  = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign rd_en = pop & !empty;
  // A full FIFO still takes a push when the head leaves on the same edge
  assign wr_en = push & (!full | rd_en);
  assign dout  = mem[rd_ptr];

  // Storage and pointer/count update; pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) mem[wr_ptr] <= din;
      wr_ptr <= wr_en ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr <= rd_en ? rd_ptr + AW'(1) : rd_ptr;
      count  <= count + (AW+1)'(wr_en) - (AW+1)'(rd_en);
    end
  end

endmodule

// File: rtl/pipe_result_collector.sv
// pipe_result_collector: tracks pipeline2 issues, captures {y,x} results into a FIFO and grants credit to the issuer
module pipe_result_collector
  import pipe_collect_pkg::*;
#(
  parameter int LAT   = PIPE2_LAT,
  parameter int DEPTH = 4,
  parameter int CNTW  = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            x_i,
  input  logic            y_i,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [1:0]      out_data,
  output logic            overflow,
  output logic [CNTW-1:0] drop_cnt
);

  logic [LAT-1:0]         vsr;
  logic                   push;
  logic                   pop;
  logic                   full;
  logic                   empty;
  logic                   drop;
  logic [$clog2(DEPTH):0] fifo_count;
  result_t                din;
  result_t                head;

  // The oldest tracked issue has its result on x_i/y_i right now
  assign push      = vsr[LAT-1];
  assign din       = '{y: y_i, x: x_i};
  assign pop       = out_valid & out_ready;
  assign drop      = push & full & !pop;
  assign out_valid = !empty;
  assign out_data  = head;
  // Every tracked issue, including one landing this cycle, reserves a FIFO slot
  assign in_ready  = (32'(fifo_count) + ones(32'(vsr))) < 32'(DEPTH);

  // Valid shift register mirrors pipeline2, which never stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vsr <= '0;
    else        vsr <= {vsr[LAT-2:0], in_valid & in_ready};
  end

  // Sticky overflow flag and saturating count of results lost to a full FIFO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      drop_cnt <= (drop_cnt == '1) ? drop_cnt : drop_cnt + CNTW'(1);
    end
  end

  pc_fifo #(
    .DEPTH (DEPTH),
    .T     (result_t)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (din),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_pipe_result_collector.sv
// tb_pipe_result_collector: randomized bench against a queue/timestamp model of the collector
module tb_pipe_result_collector;

  localparam int LAT   = 3;
  localparam int DEPTH = 4;
  localparam int CNTW  = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            x_i = 1'b0;
  logic            y_i = 1'b0;
  logic            out_ready = 1'b0;
  logic            in_ready;
  logic            out_valid;
  logic [1:0]      out_data;
  logic            overflow;
  logic [CNTW-1:0] drop_cnt;

  int n_chk = 0;
  int n_pass = 0;

  typedef struct {
    logic [1:0] d;
    int         due;
  } pend_t;

  pend_t      pend[$];
  logic [1:0] q[$];
  int         cyc = 0;
  int         drops = 0;
  logic       ovf = 1'b0;
  logic       fp = 1'b0;

  always #5 clk = ~clk;

  pipe_result_collector #(
    .LAT   (LAT),
    .DEPTH (DEPTH),
    .CNTW  (CNTW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_i       (x_i),
    .y_i       (y_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Results issued but not yet popped or dropped may never exceed the FIFO size
  function automatic logic m_ready();
    return (pend.size() + q.size()) < DEPTH;
  endfunction

  // One clock: drive inputs, check outputs, then advance the model across the edge
  task automatic cycle(input logic v, input logic r, input logic [1:0] d);
    logic       iss;
    logic       pp;
    logic       due;
    logic [1:0] xy;
    in_valid  = v;
    out_ready = r;
    due = pend.size() > 0 && pend[0].due == cyc;
    xy  = due ? pend[0].d : 2'($urandom);
    {y_i, x_i} = xy;
    if (fp) force dut.push = 1'b1;
    else    release dut.push;
    #1;
    chk("in_ready", 32'(in_ready), 32'(m_ready()));
    chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
    if (q.size() > 0) chk("out_data", 32'(out_data), 32'(q[0]));
    chk("overflow", 32'(overflow), 32'(ovf));
    chk("drop_cnt", 32'(drop_cnt), (drops > 255) ? 32'd255 : 32'(drops));
    iss = v && m_ready();
    pp  = r && q.size() > 0;
    @(posedge clk);
    if (due || fp) begin
      if (due) void'(pend.pop_front());
      if (q.size() == DEPTH && !pp) begin
        ovf = 1'b1;
        drops++;
      end else begin
        if (pp) void'(q.pop_front());
        q.push_back(xy);
        pp = 1'b0;
      end
    end
    if (pp) void'(q.pop_front());
    if (iss) pend.push_back('{d: d, due: cyc + LAT});
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    int n;
    int guard;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    rst_n = 1'b1;
    repeat (10) cycle(1'b0, 1'b0, 2'b00);
    chk("idle_out_valid", 32'(out_valid), 32'd0);

    cycle(1'b1, 1'b0, 2'b11);
    repeat (3) cycle(1'b0, 1'b0, 2'b00);
    chk("single_valid", 32'(out_valid), 32'd1);
    chk("single_data", 32'(out_data), 32'd3);
    repeat (3) cycle(1'b0, 1'b1, 2'b00);
    chk("single_popped", 32'(out_valid), 32'd0);

    repeat (8) cycle(1'b1, 1'b0, 2'($urandom));
    chk("fill_in_ready", 32'(in_ready), 32'd0);
    chk("fill_overflow", 32'(overflow), 32'd0);
    repeat (6) cycle(1'b0, 1'b1, 2'b00);

    n = 0;
    guard = 0;
    while (n < 8 && guard < 100) begin
      if (m_ready()) n++;
      cycle(1'b1, 1'b1, 2'($urandom));
      guard++;
    end
    chk("burst_bound", 32'(guard < 100), 32'd1);
    repeat (8) cycle(1'b0, 1'b1, 2'b00);

    repeat (8) cycle(1'b1, 1'b0, 2'($urandom));
    repeat (4) cycle(1'b0, 1'b0, 2'b00);
    fp = 1'b1;
    cycle(1'b0, 1'b0, 2'b00);
    fp = 1'b0;
    cycle(1'b0, 1'b0, 2'b00);
    chk("ovf_first", 32'(overflow), 32'd1);
    chk("drop_first", 32'(drop_cnt), 32'd1);
    fp = 1'b1;
    repeat (255) cycle(1'b0, 1'b0, 2'b00);
    fp = 1'b0;
    cycle(1'b0, 1'b0, 2'b00);
    chk("drop_sat", 32'(drop_cnt), 32'd255);
    repeat (6) cycle(1'b0, 1'b1, 2'b00);

    repeat (4) cycle(1'b1, 1'b0, 2'($urandom));
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_overflow", 32'(overflow), 32'd0);
    chk("mid_rst_drop_cnt", 32'(drop_cnt), 32'd0);
    pend.delete();
    q.delete();
    ovf = 1'b0;
    drops = 0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) cycle(1'b0, 1'b1, 2'b00);

    repeat (400) cycle(1'($urandom), ($urandom % 4) != 0, 2'($urandom));
    repeat (10) cycle(1'b0, 1'b1, 2'b00);
    chk("end_empty", 32'(out_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
